// File: rtl/mem_access_pkg.sv
// Shared encodings for the memory access unit: access sizes, exception codes,
// FSM states and the registered response payload.
package mem_access_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned WHBS_W = 2;
   localparam int unsigned EXC_W  = 2;

   localparam logic [WHBS_W-1:0] WHBS_WORD = 2'b11;
   localparam logic [WHBS_W-1:0] WHBS_HALF = 2'b01;
   localparam logic [WHBS_W-1:0] WHBS_BYTE = 2'b00;
   localparam logic [WHBS_W-1:0] WHBS_RSVD = 2'b10;

   localparam logic [EXC_W-1:0] EXC_NONE       = 2'b00;
   localparam logic [EXC_W-1:0] EXC_LOAD_UNAL  = 2'b01;
   localparam logic [EXC_W-1:0] EXC_STORE_UNAL = 2'b10;
   localparam logic [EXC_W-1:0] EXC_ILL_SIZE   = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_WAIT   = 2'd2,
      ST_RESP   = 2'd3
   } state_t;

   typedef struct packed {
      logic              exc;
      logic [EXC_W-1:0]  code;
      logic [ADDR_W-1:0] badaddr;
      logic [DATA_W-1:0] rdata;
   } rsp_payload_t;

   // Half needs bit 0 clear, word needs bits 1:0 clear.
   function automatic logic is_misaligned(input logic [WHBS_W-1:0] whbs,
                                          input logic [1:0]        lsb);
      logic mis;
      mis = 1'b0;
      if (whbs == WHBS_HALF)      mis = lsb[0];
      else if (whbs == WHBS_WORD) mis = (lsb != 2'b00);
      return mis;
   endfunction

endpackage

// File: rtl/mem_load_extend.sv
// Sign/zero extension of right-aligned RAM read data to a full 32-bit result.
module mem_load_extend
   import mem_access_pkg::*;
(
   input  logic [DATA_W-1:0] i_dout,
   input  logic [WHBS_W-1:0] i_whbs,
   input  logic              i_signed,
   output logic [DATA_W-1:0] o_data_c
);

   always_comb begin
      o_data_c = i_dout;
      case (i_whbs)
         WHBS_BYTE: o_data_c = {{24{i_signed & i_dout[7]}},  i_dout[7:0]};
         WHBS_HALF: o_data_c = {{16{i_signed & i_dout[15]}}, i_dout[15:0]};
         default:   o_data_c = i_dout;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator driving the data-RAM port set for the memory stage.
// Optional MEM_ACCESS_PRECHECK_EN: local alignment check at request acceptance.
module mem_access_unit
   import mem_access_pkg::*;
#(
   parameter int unsigned TAG_W  = 5,
   parameter int unsigned RD_LAT = 0
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              REQ_VALID,
   output logic              REQ_READY,
   input  logic              REQ_WE,
   input  logic [WHBS_W-1:0] REQ_WHBS,
   input  logic              REQ_SIGNED,
   input  logic [ADDR_W-1:0] REQ_ADDR,
   input  logic [DATA_W-1:0] REQ_WDATA,
   input  logic [TAG_W-1:0]  REQ_TAG,
   output logic              RSP_VALID,
   input  logic              RSP_READY,
   output logic [DATA_W-1:0] RSP_RDATA,
   output logic [TAG_W-1:0]  RSP_TAG,
   output logic              RSP_EXC,
   output logic [EXC_W-1:0]  RSP_EXC_CODE,
   output logic [ADDR_W-1:0] RSP_BADADDR,
   output logic              WE,
   output logic [WHBS_W-1:0] RWHBS,
   output logic [WHBS_W-1:0] WWHBS,
   output logic [ADDR_W-1:0] RADDR,
   output logic [ADDR_W-1:0] WADDR,
   output logic [DATA_W-1:0] DIN,
   input  logic [DATA_W-1:0] DOUT,
   input  logic              RUnalExc,
   input  logic              WUnalExc
);

   state_t            r_state;
   state_t            w_next_state;
   logic              r_req_ready;
   logic              r_we;
   logic              r_rsp_valid;
   rsp_payload_t      r_rsp;
   logic [TAG_W-1:0]  r_rsp_tag;
   logic [WHBS_W-1:0] r_rwhbs;
   logic [WHBS_W-1:0] r_wwhbs;
   logic [ADDR_W-1:0] r_raddr;
   logic [ADDR_W-1:0] r_waddr;
   logic [DATA_W-1:0] r_din;

   logic              r_cap_we;
   logic [WHBS_W-1:0] r_cap_whbs;
   logic              r_cap_signed;
   logic [ADDR_W-1:0] r_cap_addr;
   logic [TAG_W-1:0]  r_cap_tag;

   logic              w_accept;
   logic              w_issue;
   logic              w_early;
   logic              w_sample;
   logic              w_ram_unal;
   logic [EXC_W-1:0]  w_early_code;
   logic [DATA_W-1:0] w_ext_data;

   mem_load_extend u_extend (
      .i_dout   (DOUT),
      .i_whbs   (r_cap_whbs),
      .i_signed (r_cap_signed),
      .o_data_c (w_ext_data)
   );

`ifdef MEM_ACCESS_PRECHECK_EN
   logic w_unused_unal;
   assign w_unused_unal = RUnalExc | WUnalExc;
   assign w_ram_unal    = 1'b0;
`else
   assign w_ram_unal = r_cap_we ? WUnalExc : RUnalExc;
`endif

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) r_state <= ST_IDLE;
      else     r_state <= w_next_state;
   end

   // Next state; w_sample marks the cycle whose closing edge captures RAM results.
   always_comb begin
      w_next_state = r_state;
      w_early_code = EXC_NONE;
      w_sample     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (REQ_VALID) begin
               if (REQ_WHBS == WHBS_RSVD) begin
                  w_next_state = ST_RESP;
                  w_early_code = EXC_ILL_SIZE;
               end
`ifdef MEM_ACCESS_PRECHECK_EN
               else if (is_misaligned(REQ_WHBS, REQ_ADDR[1:0])) begin
                  w_next_state = ST_RESP;
                  w_early_code = REQ_WE ? EXC_STORE_UNAL : EXC_LOAD_UNAL;
               end
`endif
               else begin
                  w_next_state = ST_ACCESS;
               end
            end
         end
         ST_ACCESS: begin
            if (r_cap_we || (RD_LAT == 0)) begin
               w_next_state = ST_RESP;
               w_sample     = 1'b1;
            end else begin
               w_next_state = ST_WAIT;
            end
         end
         ST_WAIT: begin
            w_next_state = ST_RESP;
            w_sample     = 1'b1;
         end
         ST_RESP: begin
            if (RSP_READY) w_next_state = ST_IDLE;
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   assign w_accept = (r_state == ST_IDLE) && REQ_VALID;
   assign w_issue  = w_accept && (w_next_state == ST_ACCESS);
   assign w_early  = w_accept && (w_next_state == ST_RESP);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_req_ready  <= 1'b1;
         r_we         <= 1'b0;
         r_rsp_valid  <= 1'b0;
         r_rsp        <= '0;
         r_rsp_tag    <= '0;
         r_rwhbs      <= '0;
         r_wwhbs      <= '0;
         r_raddr      <= '0;
         r_waddr      <= '0;
         r_din        <= '0;
         r_cap_we     <= 1'b0;
         r_cap_whbs   <= '0;
         r_cap_signed <= 1'b0;
         r_cap_addr   <= '0;
         r_cap_tag    <= '0;
      end else begin
         r_req_ready <= (w_next_state == ST_IDLE);
         r_we        <= w_issue && REQ_WE;

         if (w_accept) begin
            r_cap_we     <= REQ_WE;
            r_cap_whbs   <= REQ_WHBS;
            r_cap_signed <= REQ_SIGNED;
            r_cap_addr   <= REQ_ADDR;
            r_cap_tag    <= REQ_TAG;
         end

         // RAM side only moves for requests that actually reach the RAM.
         if (w_issue) begin
            if (REQ_WE) begin
               r_waddr <= REQ_ADDR;
               r_wwhbs <= REQ_WHBS;
               r_din   <= REQ_WDATA;
            end else begin
               r_raddr <= REQ_ADDR;
               r_rwhbs <= REQ_WHBS;
            end
         end

         if (w_early) begin
            r_rsp_valid   <= 1'b1;
            r_rsp_tag     <= REQ_TAG;
            r_rsp.exc     <= 1'b1;
            r_rsp.code    <= w_early_code;
            r_rsp.badaddr <= REQ_ADDR;
            r_rsp.rdata   <= '0;
         end else if (w_sample) begin
            r_rsp_valid <= 1'b1;
            r_rsp_tag   <= r_cap_tag;
            if (w_ram_unal) begin
               r_rsp.exc     <= 1'b1;
               r_rsp.code    <= r_cap_we ? EXC_STORE_UNAL : EXC_LOAD_UNAL;
               r_rsp.badaddr <= r_cap_addr;
               r_rsp.rdata   <= '0;
            end else begin
               r_rsp.exc     <= 1'b0;
               r_rsp.code    <= EXC_NONE;
               r_rsp.badaddr <= '0;
               r_rsp.rdata   <= r_cap_we ? DATA_W'(0) : w_ext_data;
            end
         end else if ((r_state == ST_RESP) && RSP_READY) begin
            r_rsp_valid <= 1'b0;
         end
      end
   end

   assign REQ_READY    = r_req_ready;
   assign RSP_VALID    = r_rsp_valid;
   assign RSP_RDATA    = r_rsp.rdata;
   assign RSP_TAG      = r_rsp_tag;
   assign RSP_EXC      = r_rsp.exc;
   assign RSP_EXC_CODE = r_rsp.code;
   assign RSP_BADADDR  = r_rsp.badaddr;
   assign WE           = r_we;
   assign RWHBS        = r_rwhbs;
   assign WWHBS        = r_wwhbs;
   assign RADDR        = r_raddr;
   assign WADDR        = r_waddr;
   assign DIN          = r_din;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: one instance per read latency, each with a byte RAM model.
module tb_mem_access_unit;

   typedef struct {
      logic [4:0]  tag;
      logic [31:0] rdata;
      logic        exc;
      logic [1:0]  code;
      logic [31:0] bad;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        req_valid [2];
   logic        rsp_ready [2];
   logic        req_we;
   logic [1:0]  req_whbs;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [4:0]  req_tag;

   logic        req_ready [2];
   logic        rsp_valid [2];
   logic [31:0] rsp_rdata [2];
   logic [4:0]  rsp_tag   [2];
   logic        rsp_exc   [2];
   logic [1:0]  rsp_code  [2];
   logic [31:0] rsp_bad   [2];
   logic        we        [2];
   logic [1:0]  rwhbs     [2];
   logic [1:0]  wwhbs     [2];
   logic [31:0] raddr     [2];
   logic [31:0] waddr     [2];
   logic [31:0] din       [2];
   logic [31:0] dout      [2];
   logic        runal     [2];
   logic        wunal     [2];

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_checks;
   int   n_errors;
   int   we_cnt [2];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_inst
      logic [7:0]  mem [64];
      logic [5:0]  ri;
      logic [5:0]  wi;
      logic [31:0] rd_c;
      logic [31:0] rd_q;

      mem_access_unit #(.TAG_W(5), .RD_LAT(g)) u_dut (
         .CLK          (clk),
         .RST          (rst),
         .REQ_VALID    (req_valid[g]),
         .REQ_READY    (req_ready[g]),
         .REQ_WE       (req_we),
         .REQ_WHBS     (req_whbs),
         .REQ_SIGNED   (req_signed),
         .REQ_ADDR     (req_addr),
         .REQ_WDATA    (req_wdata),
         .REQ_TAG      (req_tag),
         .RSP_VALID    (rsp_valid[g]),
         .RSP_READY    (rsp_ready[g]),
         .RSP_RDATA    (rsp_rdata[g]),
         .RSP_TAG      (rsp_tag[g]),
         .RSP_EXC      (rsp_exc[g]),
         .RSP_EXC_CODE (rsp_code[g]),
         .RSP_BADADDR  (rsp_bad[g]),
         .WE           (we[g]),
         .RWHBS        (rwhbs[g]),
         .WWHBS        (wwhbs[g]),
         .RADDR        (raddr[g]),
         .WADDR        (waddr[g]),
         .DIN          (din[g]),
         .DOUT         (dout[g]),
         .RUnalExc     (runal[g]),
         .WUnalExc     (wunal[g])
      );

      initial for (int k = 0; k < 64; k++) mem[k] = 8'h00;

      assign ri = raddr[g][5:0];
      assign wi = waddr[g][5:0];
      assign runal[g] = (rwhbs[g] == 2'b01 && raddr[g][0]) || (rwhbs[g] == 2'b11 && raddr[g][1:0] != 2'b00);
      assign wunal[g] = (wwhbs[g] == 2'b01 && waddr[g][0]) || (wwhbs[g] == 2'b11 && waddr[g][1:0] != 2'b00);

      // Upper bits carry filler so the extension logic must really clear them.
      always_comb begin
         case (rwhbs[g])
            2'b00:   rd_c = {24'hA5A5A5, mem[ri]};
            2'b01:   rd_c = {16'hA5A5, mem[ri + 6'd1], mem[ri]};
            default: rd_c = {mem[ri + 6'd3], mem[ri + 6'd2], mem[ri + 6'd1], mem[ri]};
         endcase
      end

      always @(posedge clk) rd_q <= rd_c;
      assign dout[g] = (g == 0) ? rd_c : rd_q;

      always @(posedge clk) begin
         if (we[g] && !wunal[g]) begin
            mem[wi] <= din[g][7:0];
            if (wwhbs[g] != 2'b00) mem[wi + 6'd1] <= din[g][15:8];
            if (wwhbs[g] == 2'b11) begin
               mem[wi + 6'd2] <= din[g][23:16];
               mem[wi + 6'd3] <= din[g][31:24];
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic bit misaligned(input logic [1:0] whbs, input logic [31:0] addr);
      return (whbs == 2'b01 && addr[0]) || (whbs == 2'b11 && addr[1:0] != 2'b00);
   endfunction

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (we[i]) we_cnt[i] <= we_cnt[i] + 1;
         if (!rst && rsp_valid[i] && rsp_ready[i]) begin
            if (exp_q.size() == 0) begin
               check("unexpected_rsp", 32'd1, 32'd0);
            end else begin
               mon_e = exp_q.pop_front();
               check("rsp_tag",   32'(rsp_tag[i]),  32'(mon_e.tag));
               check("rsp_rdata", rsp_rdata[i],     mon_e.rdata);
               check("rsp_exc",   32'(rsp_exc[i]),  32'(mon_e.exc));
               check("rsp_code",  32'(rsp_code[i]), 32'(mon_e.code));
               check("rsp_bad",   rsp_bad[i],       mon_e.bad);
            end
         end
      end
   end

   // One request on instance i; lat = negedges from acceptance until RSP_VALID is seen.
   task automatic do_req(input int i, input logic w, input logic [1:0] whbs, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] tag,
                         input logic [31:0] e_rdata, input logic [1:0] e_code,
                         input int lat, input int stall);
      exp_t e;
      int   n;
      int   we0;
      int   we_exp;
      bit   mis;
      mis    = misaligned(whbs, addr);
      we_exp = (w && whbs != 2'b10) ? 1 : 0;
`ifdef MEM_ACCESS_PRECHECK_EN
      if (mis) begin
         lat    = 1;
         we_exp = 0;
      end
`endif
      req_we       = w;
      req_whbs     = whbs;
      req_signed   = sgn;
      req_addr     = addr;
      req_wdata    = wdata;
      req_tag      = tag;
      rsp_ready[i] = (stall == 0);
      req_valid[i] = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!req_ready[i] && n < 20);
      if (!req_ready[i]) begin
         check("accept_timeout", 32'd0, 32'd1);
         req_valid[i] = 1'b0;
         return;
      end
      we0     = we_cnt[i];
      e.tag   = tag;
      e.rdata = e_rdata;
      e.exc   = (e_code != 2'b00);
      e.code  = e_code;
      e.bad   = e.exc ? addr : 32'd0;
      exp_q.push_back(e);
      @(posedge clk); #1;
      req_valid[i] = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (!rsp_valid[i] && n < 20);
      check("rsp_latency", 32'(n), 32'(lat));
      if (stall > 0 && rsp_valid[i]) begin
         for (int k = 0; k < stall; k++) begin
            check("hold_valid", 32'(rsp_valid[i]), 32'd1);
            check("hold_rdata", rsp_rdata[i], e_rdata);
            check("hold_tag",   32'(rsp_tag[i]), 32'(tag));
            check("hold_ready", 32'(req_ready[i]), 32'd0);
            check("hold_we",    32'(we[i]), 32'd0);
            if (!w) check("hold_raddr", raddr[i], addr);
            @(negedge clk);
         end
         @(posedge clk); #1;
         rsp_ready[i] = 1'b1;
         @(negedge clk);
      end
      @(posedge clk); #1;
      check("we_pulses", 32'(we_cnt[i] - we0), 32'(we_exp));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      n_checks     = 0;
      n_errors     = 0;
      we_cnt[0]    = 0;
      we_cnt[1]    = 0;
      rst          = 1'b1;
      req_valid[0] = 1'b0;
      req_valid[1] = 1'b0;
      rsp_ready[0] = 1'b1;
      rsp_ready[1] = 1'b1;
      req_we       = 1'b0;
      req_whbs     = 2'b00;
      req_signed   = 1'b0;
      req_addr     = 32'd0;
      req_wdata    = 32'd0;
      req_tag      = 5'd0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_req_ready", 32'(req_ready[0]), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
      check("rst_we",        32'(we[0]),        32'd0);
      check("rst_rdata",     rsp_rdata[0],      32'd0);
      check("rst_raddr",     raddr[0],          32'd0);
      check("rst_req_ready1", 32'(req_ready[1]), 32'd1);
      rst = 1'b0;
      @(posedge clk); #1;

      // inst, we, whbs, signed, addr, wdata, tag, exp_rdata, exp_code, latency, stall
      do_req(0, 1, 2'b11, 0, 32'd0,  32'h11111111, 5'd3,  32'h00000000, 2'b00, 2, 0);
      do_req(0, 0, 2'b11, 0, 32'd0,  32'd0,        5'd4,  32'h11111111, 2'b00, 2, 0);
      do_req(0, 1, 2'b01, 0, 32'd6,  32'h12348001, 5'd5,  32'h00000000, 2'b00, 2, 0);
      do_req(0, 0, 2'b01, 1, 32'd6,  32'd0,        5'd6,  32'hFFFF8001, 2'b00, 2, 0);
      do_req(0, 0, 2'b01, 0, 32'd6,  32'd0,        5'd7,  32'h00008001, 2'b00, 2, 0);
      do_req(0, 1, 2'b11, 0, 32'd8,  32'h33221144, 5'd8,  32'h00000000, 2'b00, 2, 0);
      do_req(0, 1, 2'b00, 0, 32'd9,  32'h5A5A5A80, 5'd9,  32'h00000000, 2'b00, 2, 0);
      do_req(0, 0, 2'b00, 1, 32'd9,  32'd0,        5'd10, 32'hFFFFFF80, 2'b00, 2, 0);
      do_req(0, 0, 2'b00, 0, 32'd9,  32'd0,        5'd11, 32'h00000080, 2'b00, 2, 0);
      do_req(0, 0, 2'b00, 0, 32'd8,  32'd0,        5'd12, 32'h00000044, 2'b00, 2, 0);
      do_req(0, 0, 2'b00, 0, 32'd10, 32'd0,        5'd13, 32'h00000022, 2'b00, 2, 0);
      do_req(0, 0, 2'b11, 1, 32'd8,  32'd0,        5'd14, 32'h33228044, 2'b00, 2, 0);
      do_req(0, 0, 2'b01, 1, 32'd5,  32'd0,        5'd15, 32'h00000000, 2'b01, 2, 0);
      do_req(0, 1, 2'b11, 0, 32'd6,  32'hDEADBEEF, 5'd16, 32'h00000000, 2'b10, 2, 0);
      do_req(0, 0, 2'b11, 0, 32'd4,  32'd0,        5'd17, 32'h80010000, 2'b00, 2, 0);
      do_req(0, 0, 2'b10, 0, 32'h10, 32'd0,        5'd18, 32'h00000000, 2'b11, 1, 0);
      do_req(0, 1, 2'b10, 0, 32'h14, 32'hFFFFFFFF, 5'd19, 32'h00000000, 2'b11, 1, 0);
      do_req(0, 0, 2'b11, 0, 32'd0,  32'd0,        5'd20, 32'h11111111, 2'b00, 2, 4);

      // Reset pulse while a store sits in ACCESS: no write, no response.
      req_we     = 1'b1;
      req_whbs   = 2'b11;
      req_signed = 1'b0;
      req_addr   = 32'h20;
      req_wdata  = 32'hCAFEF00D;
      req_tag    = 5'd21;
      req_valid[0] = 1'b1;
      @(negedge clk);
      check("pre_rst_ready", 32'(req_ready[0]), 32'd1);
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      check("access_we", 32'(we[0]), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("midrst_we",        32'(we[0]),        32'd0);
      check("midrst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_ready", 32'(req_ready[0]), 32'd1);
      @(posedge clk); #1;
      do_req(0, 0, 2'b11, 0, 32'h20, 32'd0,        5'd22, 32'h00000000, 2'b00, 2, 0);

      // Registered-read instance: loads pass through WAIT.
      do_req(1, 1, 2'b11, 0, 32'h0C, 32'hA1B2C3D4, 5'd1,  32'h00000000, 2'b00, 2, 0);
      do_req(1, 0, 2'b11, 0, 32'h0C, 32'd0,        5'd2,  32'hA1B2C3D4, 2'b00, 3, 0);
      do_req(1, 0, 2'b01, 1, 32'h0E, 32'd0,        5'd3,  32'hFFFFA1B2, 2'b00, 3, 0);
      do_req(1, 0, 2'b00, 1, 32'h0D, 32'd0,        5'd4,  32'hFFFFFFC3, 2'b00, 3, 0);
      do_req(1, 0, 2'b00, 0, 32'h0C, 32'd0,        5'd5,  32'h000000D4, 2'b00, 3, 0);
      do_req(1, 0, 2'b01, 0, 32'h0F, 32'd0,        5'd6,  32'h00000000, 2'b01, 3, 0);
      do_req(1, 0, 2'b11, 0, 32'h0C, 32'd0,        5'd7,  32'hA1B2C3D4, 2'b00, 3, 4);

      repeat (2) @(posedge clk);
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
